// File: rtl/imgbuf_mp.sv
// imgbuf_mp: one WxH frame of DW-bit pixels held in a simple-dual-port RAM.
// NRD read ports share the RAM through a round-robin arbiter. A read granted
// at edge T returns its data in the cycle after edge T+3. Out-of-frame read
// coordinates are folded (mirror or clamp) or replaced by a constant. There
// are two write ports with fixed priority and a sticky drop flag.
module imgbuf_mp #(
    parameter int XW    = 8,
    parameter int YW    = 8,
    parameter int DW    = 8,
    parameter int NRD   = 2,
    parameter int BMODE = 0,
    parameter logic [DW-1:0] BVAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        rd_req,
    output logic [NRD-1:0]        rd_gnt,
    input  logic [NRD*(XW+2)-1:0] rd_px,
    input  logic [NRD*(YW+2)-1:0] rd_py,
    output logic [NRD*DW-1:0]     rd_dt,
    output logic [NRD-1:0]        rd_vl,
    input  logic                  wr_en_1,
    input  logic [XW+1:0]         wr_px_1,
    input  logic [YW+1:0]         wr_py_1,
    input  logic [DW-1:0]         wr_dt_1,
    input  logic                  wr_en_2,
    input  logic [XW+1:0]         wr_px_2,
    input  logic [YW+1:0]         wr_py_2,
    input  logic [DW-1:0]         wr_dt_2,
    output logic                  wr_err
);
    localparam int PW    = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int AW    = XW + YW;
    localparam int CXW   = XW + 2;
    localparam int CYW   = YW + 2;
    localparam int CW    = ((XW > YW) ? XW : YW) + 3;
    localparam int DEPTH = 2 ** AW;
    localparam logic signed [CW-1:0] LIMX = CW'((2 ** XW) - 1);
    localparam logic signed [CW-1:0] LIMY = CW'((2 ** YW) - 1);

    // Fold one signed coordinate into [0, lim]. The internal width leaves room
    // for -c and 2*lim-c, so the final clamp catches every far-out input.
    function automatic logic [CW-1:0] fold(input logic signed [CW-1:0] c,
                                           input logic signed [CW-1:0] lim);
        logic signed [CW-1:0] m;
        m = c;
        if (BMODE == 0) begin
            if (c[CW-1]) begin
                m = -c;
            end else if (c > lim) begin
                m = (lim <<< 1) - c;
            end
        end
        if (m[CW-1]) begin
            m = '0;
        end else if (m > lim) begin
            m = lim;
        end
        return m;
    endfunction

    // Arbiter state: index of the most recently granted port.
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           gnt_any;
    logic [PW-1:0]  gnt_idx;

    // Stage 1: granted port and raw coordinates.
    logic           s1_vl_q, s1_vl_d;
    logic [PW-1:0]  s1_pid_q, s1_pid_d;
    logic [CXW-1:0] s1_px_q, s1_px_d;
    logic [CYW-1:0] s1_py_q, s1_py_d;

    // Stage 2: folded RAM address and out-of-frame flag.
    logic           s2_vl_q, s2_vl_d;
    logic [PW-1:0]  s2_pid_q, s2_pid_d;
    logic [AW-1:0]  s2_addr_q, s2_addr_d;
    logic           s2_oob_q, s2_oob_d;

    // Stage 3: RAM data register alongside its tags.
    logic           s3_vl_q, s3_vl_d;
    logic [PW-1:0]  s3_pid_q, s3_pid_d;
    logic           s3_oob_q, s3_oob_d;
    logic [DW-1:0]  ram_dt_q;
    logic [DW-1:0]  px_val;

    // Output register.
    logic [NRD-1:0]    vl_q, vl_d;
    logic [NRD*DW-1:0] dt_q, dt_d;

    // Write register and sticky error flag.
    logic           wr_vl_q, wr_vl_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [DW-1:0]  wr_dt_q, wr_dt_d;
    logic           err_q, err_d;
    logic           w1_in, w2_in, w1_ok, w2_ok;

    logic [DW-1:0]  mem [DEPTH];

    // Round-robin search starting one port past the last grant; no grant during reset.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NRD; i++) begin
            idx = (int'(ptr_q) + 1 + i) % NRD;
            if (!gnt_any && rd_req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
        rd_gnt = gnt_any ? (NRD'(1) << gnt_idx) : '0;
        ptr_d  = gnt_any ? gnt_idx : ptr_q;
    end

    // Read pipeline next-state: capture, fold to an address, then tag the RAM data.
    always_comb begin
        logic signed [CW-1:0] cx;
        logic signed [CW-1:0] cy;
        s1_vl_d   = gnt_any;
        s1_pid_d  = gnt_idx;
        s1_px_d   = rd_px[gnt_idx*CXW +: CXW];
        s1_py_d   = rd_py[gnt_idx*CYW +: CYW];

        cx        = CW'($signed(s1_px_q));
        cy        = CW'($signed(s1_py_q));
        s2_vl_d   = s1_vl_q;
        s2_pid_d  = s1_pid_q;
        s2_addr_d = {YW'(fold(cy, LIMY)), XW'(fold(cx, LIMX))};
        s2_oob_d  = (|s1_px_q[CXW-1:XW]) | (|s1_py_q[CYW-1:YW]);

        s3_vl_d   = s2_vl_q;
        s3_pid_d  = s2_pid_q;
        s3_oob_d  = s2_oob_q;

        px_val    = ((BMODE == 2) && s3_oob_q) ? BVAL : ram_dt_q;
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_out
            logic hit;
            assign hit                = s3_vl_q && (s3_pid_q == PW'(gi));
            assign vl_d[gi]           = hit;
            assign dt_d[gi*DW +: DW]  = hit ? px_val : '0;
        end
    endgenerate

    // Write arbitration: port 1 wins, in-range check on both, sticky drop flag.
    always_comb begin
        w1_in     = ~(|wr_px_1[CXW-1:XW]) & ~(|wr_py_1[CYW-1:YW]);
        w2_in     = ~(|wr_px_2[CXW-1:XW]) & ~(|wr_py_2[CYW-1:YW]);
        w1_ok     = wr_en_1 & w1_in;
        w2_ok     = wr_en_2 & ~wr_en_1 & w2_in;
        wr_vl_d   = w1_ok | w2_ok;
        wr_addr_d = w1_ok ? {wr_py_1[YW-1:0], wr_px_1[XW-1:0]}
                          : {wr_py_2[YW-1:0], wr_px_2[XW-1:0]};
        wr_dt_d   = w1_ok ? wr_dt_1 : wr_dt_2;
        err_d     = err_q | (wr_en_1 & wr_en_2) | (wr_en_1 & ~w1_in) | (wr_en_2 & ~w2_in);
    end

    // State registers: valids, pointer and flags reset; payloads just follow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= PW'(NRD - 1);
            s1_vl_q <= 1'b0;
            s2_vl_q <= 1'b0;
            s3_vl_q <= 1'b0;
            vl_q    <= '0;
            dt_q    <= '0;
            wr_vl_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            s1_vl_q <= s1_vl_d;
            s2_vl_q <= s2_vl_d;
            s3_vl_q <= s3_vl_d;
            vl_q    <= vl_d;
            dt_q    <= dt_d;
            wr_vl_q <= wr_vl_d;
            err_q   <= err_d;
        end
        s1_pid_q  <= s1_pid_d;
        s1_px_q   <= s1_px_d;
        s1_py_q   <= s1_py_d;
        s2_pid_q  <= s2_pid_d;
        s2_addr_q <= s2_addr_d;
        s2_oob_q  <= s2_oob_d;
        s3_pid_q  <= s3_pid_d;
        s3_oob_q  <= s3_oob_d;
        wr_addr_q <= wr_addr_d;
        wr_dt_q   <= wr_dt_d;
    end

    // Frame RAM: read-first, so a write committing on the read edge is not seen.
    always_ff @(posedge clk) begin
        if (wr_vl_q) begin
            mem[wr_addr_q] <= wr_dt_q;
        end
        ram_dt_q <= mem[s2_addr_q];
    end

    assign rd_vl  = vl_q;
    assign rd_dt  = dt_q;
    assign wr_err = err_q;

endmodule
